sync_fifo: RTL and testbench

//  Single-clock first-in/first-out buffer for WIDTH-bit words, DEPTH entries deep.
//  - Decouples a producer and a consumer that share one clock, using wr_en/rd_en strobes.
//  - Reports occupancy through full/empty flags.
//  - Generic datapath buffer with no protocol knowledge.

---
 rtl/sync_fifo_pkg.sv | 27 ++
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 82 ++++++++
 tb/tb_sync_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_pkg                                          |
// | Description : Shared defaults and width helpers for sync_fifo.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sync_fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_WIDTH = 8;

    // Widths for the default configuration.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointer width for an arbitrary power-of-two depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so the value DEPTH itself is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_mem                                          |
// | Description : DEPTH x WIDTH register array, synchronous write,       |
// |               combinational read.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ptr_width(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [ptr_width(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]             rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately not reset; occupancy is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read is combinational so the owner can register it in the same edge.
    assign rdata = r_mem[raddr];

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo                                              |
// | Description : Single-clock FIFO with registered read data and        |
// |               count-decoded full/empty flags.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int                 c_PTR_W    = ptr_width(DEPTH);
    localparam int                 c_CNT_W    = cnt_width(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_dout;
    logic [WIDTH-1:0]   w_rdata;
    logic               w_wr_ok;
    logic               w_rd_ok;

    // Flags decode straight from the count register.
    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL_CNT);

    // A read on a full FIFO frees the slot the write lands in this same edge.
    assign w_wr_ok = wr_en & (~full | rd_en);
    assign w_rd_ok = rd_en & ~empty;

    assign dout = r_dout;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_ok),
        .waddr (r_wr_ptr),
        .wdata (din),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Pointer, occupancy and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_dout   <= w_rdata;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sync_fifo                                           |
// | Description : Self-checking bench for sync_fifo with a queue-based   |
// |               reference model.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sync_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the FIFO contents as a queue plus the last word read.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (din),
        .full  (full),
        .rd_en (rd_en),
        .dout  (dout),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Compare all outputs against the model.
    task automatic check_model(input string tag);
        check({tag, ".dout"},  32'(dout),  32'(model_dout));
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    endtask

    // One clock with the given strobes; the model follows the FIFO rules.
    task automatic step(input bit wr, input bit rd, input logic [WIDTH-1:0] d, input string tag);
        bit m_full, m_empty, rd_ok, wr_ok;
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        rd_ok = rd && !m_empty;
        wr_ok = wr && (!m_full || rd);
        if (rd_ok) model_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_model(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] rnd;
        logic [WIDTH-1:0] first_word;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        model_dout = '0;

        // Reset state.
        #12;
        check("reset.dout",  32'(dout),  32'h0);
        check("reset.empty", 32'(empty), 32'h1);
        check("reset.full",  32'(full),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single word in and out.
        step(1, 0, 8'd124, "single_wr");
        check("single_wr.empty0", 32'(empty), 32'h0);
        step(0, 1, 8'h00, "single_rd");
        check("single_rd.dout124", 32'(dout), 32'd124);
        check("single_rd.empty1", 32'(empty), 32'h1);

        // Fill with random data, then overflow twice.
        for (int i = 0; i < DEPTH; i++) begin
            rnd = WIDTH'($urandom);
            if (i == 0) first_word = rnd;
            step(1, 0, rnd, "fill_rand");
        end
        check("fill_rand.full1", 32'(full), 32'h1);
        for (int i = 0; i < 2; i++) step(1, 0, WIDTH'($urandom), "overflow");
        check("overflow.count16", 32'(model_q.size()), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 8'h00, "drain_rand");
            if (i == 0) check("drain_rand.first", 32'(dout), 32'(first_word));
        end

        // Underflow: dout holds the last valid word.
        for (int i = 0; i < 2; i++) step(0, 1, 8'h00, "underflow");

        // Wrap-around with order preserved.
        for (int i = 0; i < DEPTH; i++) step(1, 0, WIDTH'(i), "wrap_fill");
        step(0, 1, 8'h00, "wrap_rd0");
        check("wrap_rd0.value", 32'(dout), 32'd0);
        step(0, 1, 8'h00, "wrap_rd1");
        check("wrap_rd1.value", 32'(dout), 32'd1);
        step(1, 0, 8'h77, "wrap_wr77");
        for (int i = 2; i < DEPTH; i++) begin
            step(0, 1, 8'h00, "wrap_rd");
            check("wrap_rd.order", 32'(dout), 32'(i));
        end
        step(0, 1, 8'h00, "wrap_rd77");
        check("wrap_rd77.value", 32'(dout), 32'h77);
        check("wrap_rd77.empty", 32'(empty), 32'h1);

        // Simultaneous read/write, empty read+write is write-only.
        step(1, 1, 8'hAA, "rw_empty");
        check("rw_empty.nobypass", 32'(dout), 32'h77);
        step(0, 1, 8'h00, "rw_empty_rd");
        check("rw_empty_rd.value", 32'(dout), 32'hAA);
        step(1, 0, 8'h55, "rw_wr55");
        step(1, 1, 8'h99, "rw_both");
        check("rw_both.dout55", 32'(dout), 32'h55);
        check("rw_both.count1", 32'(model_q.size()), 32'd1);
        step(0, 1, 8'h00, "rw_rd99");
        check("rw_rd99.value", 32'(dout), 32'h99);
        check("rw_rd99.empty", 32'(empty), 32'h1);

        // Simultaneous read/write while full.
        for (int i = 0; i < DEPTH; i++) step(1, 0, WIDTH'($urandom), "full_fill");
        step(1, 1, 8'hC3, "rw_full");
        check("rw_full.full1", 32'(full), 32'h1);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, "full_drain");
        check("full_drain.lastC3", 32'(dout), 32'hC3);

        // Random mixed traffic.
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
                 WIDTH'($urandom), "random");
        end

        // Asynchronous reset mid-operation.
        while (model_q.size() > 0) step(0, 1, 8'h00, "pre_reset_drain");
        for (int i = 0; i < 12; i++) step(1, 0, WIDTH'($urandom), "pre_reset_fill");
        step(0, 1, 8'h00, "pre_reset_rd");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_q.delete();
        model_dout = '0;
        check("async_rst.empty", 32'(empty), 32'h1);
        check("async_rst.full",  32'(full),  32'h0);
        check("async_rst.dout",  32'(dout),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 8'h00, "post_reset_rd");
        check("post_reset_rd.dout", 32'(dout), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
